mc_controller: RTL

Multicycle control unit for the MIPS datapath. It sequences every instruction through FETCH/DECODE/EXEC/MEM/WB states. Each cycle it drives the datapath's control inputs from its own state register, the decoded `op`/`funct` fields and the ALU `zero` flag. It sits beside the datapath and is its only source of control; it also keeps a retired-instruction counter and a sticky illegal-opcode flag for debug.

---
 rtl/mc_pkg.sv | 77 +++++++
 rtl/mc_decode.sv | 54 +++++
 rtl/mc_controller.sv | 160 ++++++++++++++++
 3 files changed

// File: rtl/mc_pkg.sv
// Shared definitions for the multicycle MIPS control unit.
//   - state_t : controller state codes (exposed on the debug 'state' port)
//   - cls_t   : instruction class produced by mc_decode
//   - opcode / funct constants and datapath control encodings
package mc_pkg;

  typedef enum logic [3:0] {
    ST_INIT   = 4'd0,
    ST_FETCH  = 4'd1,
    ST_DECODE = 4'd2,
    ST_EXEC   = 4'd3,
    ST_MEM_RD = 4'd4,
    ST_MEM_WR = 4'd5,
    ST_WB_ALU = 4'd6,
    ST_WB_MEM = 4'd7,
    ST_BRANCH = 4'd8,
    ST_JUMP   = 4'd9,
    ST_HALT   = 4'd10
  } state_t;

  typedef enum logic [2:0] {
    CLS_R   = 3'd0,
    CLS_I   = 3'd1,
    CLS_LW  = 3'd2,
    CLS_SW  = 3'd3,
    CLS_BEQ = 3'd4,
    CLS_J   = 3'd5,
    CLS_JAL = 3'd6,
    CLS_ILL = 3'd7
  } cls_t;

  // Opcodes (IR[31:26])
  localparam logic [5:0] OP_RTYPE = 6'b000000;
  localparam logic [5:0] OP_ADDIU = 6'b001001;
  localparam logic [5:0] OP_ORI   = 6'b001101;
  localparam logic [5:0] OP_LUI   = 6'b001111;
  localparam logic [5:0] OP_LW    = 6'b100011;
  localparam logic [5:0] OP_SW    = 6'b101011;
  localparam logic [5:0] OP_BEQ   = 6'b000100;
  localparam logic [5:0] OP_J     = 6'b000010;
  localparam logic [5:0] OP_JAL   = 6'b000011;

  // R-type function codes (IR[5:0])
  localparam logic [5:0] FN_ADDU = 6'b100001;
  localparam logic [5:0] FN_SUBU = 6'b100011;
  localparam logic [5:0] FN_AND  = 6'b100100;
  localparam logic [5:0] FN_OR   = 6'b100101;
  localparam logic [5:0] FN_SLT  = 6'b101010;

  // Next-PC select
  localparam logic [1:0] NPC_PLUS4  = 2'b00;
  localparam logic [1:0] NPC_BRANCH = 2'b01;
  localparam logic [1:0] NPC_JUMP   = 2'b10;

  // ALU operation
  localparam logic [3:0] ALU_ADD = 4'b0000;
  localparam logic [3:0] ALU_SUB = 4'b0001;
  localparam logic [3:0] ALU_AND = 4'b0010;
  localparam logic [3:0] ALU_OR  = 4'b0011;
  localparam logic [3:0] ALU_SLT = 4'b0100;

  // Immediate extension
  localparam logic [1:0] EXT_ZERO = 2'b00;
  localparam logic [1:0] EXT_SIGN = 2'b01;
  localparam logic [1:0] EXT_LUI  = 2'b10;

  // Register write address select
  localparam logic [1:0] X1_RT = 2'b00;
  localparam logic [1:0] X1_RD = 2'b01;
  localparam logic [1:0] X1_RA = 2'b10;

  // Register write data select
  localparam logic [1:0] X2_ALU = 2'b00;
  localparam logic [1:0] X2_DM  = 2'b01;
  localparam logic [1:0] X2_PC  = 2'b10;

endpackage

// File: rtl/mc_decode.sv
// Combinational instruction decoder.
//   op, funct -> cls     : instruction class
//                aluop   : ALU operation for EXEC..end of instruction
//                extop   : immediate extension mode
//                sel     : ALU B source (1 = immediate)
//                x1_src  : register write address select
//                legal   : 0 for any unsupported op/funct pair
module mc_decode
  import mc_pkg::*;
(
  input  logic [5:0] op,
  input  logic [5:0] funct,
  output cls_t       cls,
  output logic [3:0] aluop,
  output logic [1:0] extop,
  output logic       sel,
  output logic [1:0] x1_src,
  output logic       legal
);

  always_comb begin
    cls    = CLS_ILL;
    aluop  = ALU_ADD;
    extop  = EXT_ZERO;
    sel    = 1'b0;
    x1_src = X1_RT;
    unique case (op)
      OP_RTYPE: begin
        cls    = CLS_R;
        x1_src = X1_RD;
        unique case (funct)
          FN_ADDU: aluop = ALU_ADD;
          FN_SUBU: aluop = ALU_SUB;
          FN_AND:  aluop = ALU_AND;
          FN_OR:   aluop = ALU_OR;
          FN_SLT:  aluop = ALU_SLT;
          default: cls   = CLS_ILL;
        endcase
      end
      OP_ADDIU: begin cls = CLS_I;  sel = 1'b1; extop = EXT_SIGN; aluop = ALU_ADD; end
      OP_ORI:   begin cls = CLS_I;  sel = 1'b1; extop = EXT_ZERO; aluop = ALU_OR;  end
      // lui: ALU ORs the shifted immediate with rs, which is $0 in lui encodings
      OP_LUI:   begin cls = CLS_I;  sel = 1'b1; extop = EXT_LUI;  aluop = ALU_OR;  end
      OP_LW:    begin cls = CLS_LW; sel = 1'b1; extop = EXT_SIGN; aluop = ALU_ADD; end
      OP_SW:    begin cls = CLS_SW; sel = 1'b1; extop = EXT_SIGN; aluop = ALU_ADD; end
      OP_BEQ:   begin cls = CLS_BEQ; extop = EXT_SIGN; aluop = ALU_SUB; end
      OP_J:     cls = CLS_J;
      OP_JAL:   begin cls = CLS_JAL; x1_src = X1_RA; end
      default:  cls = CLS_ILL;
    endcase
    legal = (cls != CLS_ILL);
  end

endmodule

// File: rtl/mc_controller.sv
// Multicycle MIPS control unit.
//   clk, rst (async, active low)
//   op, funct, zero          : IR fields and ALU zero flag from the datapath
//   npcop, PCWr, IRWr, RegWre, wren, sel, aluop, extop, x1, x2
//                            : datapath controls, combinational from state + IR
//   state                    : registered state code (debug)
//   illegal                  : sticky, set when an unsupported instruction decodes
//   icount                   : retired-instruction counter, wraps
// Handshake: none; the datapath follows the controls every cycle and the IR
// is only rewritten in FETCH, so op/funct are stable for the rest of the
// instruction.
module mc_controller
  import mc_pkg::*;
#(
  parameter int ICNT_W = 32
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [5:0]        op,
  input  logic [5:0]        funct,
  input  logic              zero,
  output logic [1:0]        npcop,
  output logic              PCWr,
  output logic              IRWr,
  output logic              RegWre,
  output logic              wren,
  output logic              sel,
  output logic [3:0]        aluop,
  output logic [1:0]        extop,
  output logic [1:0]        x1,
  output logic [1:0]        x2,
  output logic [3:0]        state,
  output logic              illegal,
  output logic [ICNT_W-1:0] icount
);

  state_t     state_q, state_d;
  cls_t       dec_cls;
  logic [3:0] dec_aluop;
  logic [1:0] dec_extop;
  logic       dec_sel;
  logic [1:0] dec_x1;
  logic       dec_legal;
  logic       retire;

  mc_decode u_decode (
    .op     (op),
    .funct  (funct),
    .cls    (dec_cls),
    .aluop  (dec_aluop),
    .extop  (dec_extop),
    .sel    (dec_sel),
    .x1_src (dec_x1),
    .legal  (dec_legal)
  );

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q <= ST_INIT;
      illegal <= 1'b0;
      icount  <= '0;
    end else begin
      state_q <= state_d;
      if (state_q == ST_DECODE && !dec_legal) illegal <= 1'b1;
      if (retire) icount <= icount + 1'b1;
    end
  end

  assign state = state_q;

  always_comb begin
    state_d = state_q;
    npcop   = NPC_PLUS4;
    PCWr    = 1'b0;
    IRWr    = 1'b0;
    RegWre  = 1'b0;
    wren    = 1'b0;
    sel     = 1'b0;
    aluop   = ALU_ADD;
    extop   = EXT_ZERO;
    x1      = X1_RT;
    x2      = X1_RT;
    retire  = 1'b0;
    unique case (state_q)
      ST_INIT: state_d = ST_FETCH;
      ST_FETCH: begin
        IRWr    = 1'b1;
        PCWr    = 1'b1;
        state_d = ST_DECODE;
      end
      ST_DECODE: begin
        if (!dec_legal) state_d = ST_HALT;
        else begin
          unique case (dec_cls)
            CLS_BEQ:        state_d = ST_BRANCH;
            CLS_J, CLS_JAL: state_d = ST_JUMP;
            default:        state_d = ST_EXEC;
          endcase
        end
      end
      // ALU operand controls are held from EXEC through the last state so
      // the datapath needs no ALU-out register.
      ST_EXEC, ST_MEM_RD, ST_MEM_WR, ST_WB_ALU, ST_WB_MEM: begin
        sel   = dec_sel;
        aluop = dec_aluop;
        extop = dec_extop;
        unique case (state_q)
          ST_EXEC: begin
            if (dec_cls == CLS_LW)      state_d = ST_MEM_RD;
            else if (dec_cls == CLS_SW) state_d = ST_MEM_WR;
            else                        state_d = ST_WB_ALU;
          end
          ST_MEM_RD: state_d = ST_WB_MEM;
          ST_MEM_WR: begin
            wren    = 1'b1;
            retire  = 1'b1;
            state_d = ST_FETCH;
          end
          ST_WB_ALU: begin
            RegWre  = 1'b1;
            x1      = dec_x1;
            x2      = X2_ALU;
            retire  = 1'b1;
            state_d = ST_FETCH;
          end
          default: begin // ST_WB_MEM
            RegWre  = 1'b1;
            x1      = X1_RT;
            x2      = X2_DM;
            retire  = 1'b1;
            state_d = ST_FETCH;
          end
        endcase
      end
      ST_BRANCH: begin
        sel     = 1'b0;
        aluop   = ALU_SUB;
        extop   = dec_extop;
        npcop   = NPC_BRANCH;
        PCWr    = zero;
        retire  = 1'b1;
        state_d = ST_FETCH;
      end
      ST_JUMP: begin
        npcop   = NPC_JUMP;
        PCWr    = 1'b1;
        retire  = 1'b1;
        state_d = ST_FETCH;
        if (dec_cls == CLS_JAL) begin
          RegWre = 1'b1;
          x1     = dec_x1;
          x2     = X2_PC;
        end
      end
      ST_HALT: state_d = ST_HALT;
      default: state_d = ST_INIT;
    endcase
  end

endmodule
